mem_io_responder: RTL and testbench

- Responder side of the CPU memory interface. The control path initiates the accesses; this block services them.
- The CPU issues one-cycle read or write strobes with an address. This block returns registered read data one cycle later, which matches the two-state load sequence of setting the address and then writing the register.
- It decodes a word-addressed map: internal RAM, plus a small MMIO page holding LEDs, switches, a TX byte FIFO and a cycle counter.
- It sits between the datapath and the board I/O.

---
 rtl/mem_io_responder_if.sv | 28 ++
 rtl/mem_io_responder.sv | 141 ++++++++++++++
 tb/tb_mem_io_responder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_responder_if.sv
// CPU-side memory bus between the control path (master) and the memory/IO responder (slave).
// Strobes are single-cycle; read data and fault come back registered one cycle later.
interface mem_io_responder_if;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_rdata;
    logic        mem_fault;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_read,
        output mem_write,
        input  mem_rdata,
        input  mem_fault
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_read,
        input  mem_write,
        output mem_rdata,
        output mem_fault
    );
endinterface

// File: rtl/mem_io_responder.sv
// Memory/IO responder: word-addressed RAM plus an MMIO page (LEDs, switches, TX FIFO, counter).
// Every strobe is serviced in one cycle; read data and fault pulses are registered.
module mem_io_responder #(
    parameter int unsigned RAM_WORDS  = 1024,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    mem_io_responder_if.slave       bus,
    output logic [9:0]              led_out,
    input  logic [9:0]              sw_in,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready
);
    localparam int unsigned RamAw = $clog2(RAM_WORDS);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;

    localparam logic [15:0] AddrLed    = 16'hFF00;
    localparam logic [15:0] AddrSw     = 16'hFF01;
    localparam logic [15:0] AddrFifo   = 16'hFF02;
    localparam logic [15:0] AddrCnt    = 16'hFF03;
    localparam logic [15:0] AddrShadow = 16'hFF04;

    logic [15:0] ram [RAM_WORDS];
    logic [7:0]  fifo_mem [FIFO_DEPTH];

    logic [15:0]     rdata_q, rdata_d;
    logic            fault_q, fault_d;
    logic [9:0]      led_q, led_d;
    logic [9:0]      sw_meta_q, sw_sync_q;
    logic            ovf_q, ovf_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [15:0]     shadow_q, shadow_d;
    logic [PtrW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic acc_rd, acc_wr, any_acc;
    logic hit_ram, hit_led, hit_sw, hit_fifo, hit_cnt, hit_shadow, mapped;
    logic fifo_full, fifo_empty, push_req, push, pop, ram_we;
    logic [15:0] status;

    // A read that coincides with a write is dropped; the write still lands.
    always_comb begin
        acc_wr     = bus.mem_write;
        acc_rd     = bus.mem_read && !bus.mem_write;
        any_acc    = bus.mem_read || bus.mem_write;
        hit_ram    = ({1'b0, bus.mem_addr} < 17'(RAM_WORDS));
        hit_led    = (bus.mem_addr == AddrLed);
        hit_sw     = (bus.mem_addr == AddrSw);
        hit_fifo   = (bus.mem_addr == AddrFifo);
        hit_cnt    = (bus.mem_addr == AddrCnt);
        hit_shadow = (bus.mem_addr == AddrShadow);
        mapped     = hit_ram || hit_led || hit_sw || hit_fifo || hit_cnt || hit_shadow;
    end

    always_comb begin
        fifo_full  = (count_q == CntW'(FIFO_DEPTH));
        fifo_empty = (count_q == '0);
        pop        = !fifo_empty && tx_ready;
        push_req   = acc_wr && hit_fifo;
        // Gating with reset keeps a strobe seen during reset out of the unreset storage.
        push       = push_req && (!fifo_full || pop) && reset;
        ram_we     = acc_wr && hit_ram && reset;
        status     = {ovf_q, fifo_full, fifo_empty, 5'b0, 8'(count_q)};
    end

    always_comb begin
        fault_d = (bus.mem_read && bus.mem_write)
               || (any_acc && !mapped)
               || (bus.mem_write && (hit_sw || hit_shadow));

        rdata_d = rdata_q;
        if (acc_rd) begin
            if (hit_ram)         rdata_d = ram[bus.mem_addr[RamAw-1:0]];
            else if (hit_led)    rdata_d = {6'b0, led_q};
            else if (hit_sw)     rdata_d = {6'b0, sw_sync_q};
            else if (hit_fifo)   rdata_d = status;
            else if (hit_cnt)    rdata_d = cnt_q[15:0];
            else if (hit_shadow) rdata_d = shadow_q;
            else                 rdata_d = 16'h0000;
        end

        led_d    = (acc_wr && hit_led) ? bus.mem_wdata[9:0] : led_q;
        cnt_d    = (acc_wr && hit_cnt) ? 32'd0 : cnt_q + 32'd1;
        shadow_d = (acc_rd && hit_cnt) ? cnt_q[31:16] : shadow_q;

        // A fresh overflow wins over a status-read clear in the same cycle.
        ovf_d = ovf_q;
        if (acc_rd && hit_fifo) ovf_d = 1'b0;
        if (push_req && fifo_full && !pop) ovf_d = 1'b1;

        rptr_d  = pop  ? rptr_q + PtrW'(1) : rptr_q;
        wptr_d  = push ? wptr_q + PtrW'(1) : wptr_q;
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CntW'(1);
        else if (!push && pop) count_d = count_q - CntW'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_q   <= '0;
            fault_q   <= 1'b0;
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            rptr_q    <= '0;
            wptr_q    <= '0;
            count_q   <= '0;
        end else begin
            rdata_q   <= rdata_d;
            fault_q   <= fault_d;
            led_q     <= led_d;
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            count_q   <= count_d;
        end
    end

    // Storage arrays are deliberately not reset.
    always_ff @(posedge clock) begin
        if (ram_we) ram[bus.mem_addr[RamAw-1:0]] <= bus.mem_wdata;
        if (push)   fifo_mem[wptr_q] <= bus.mem_wdata[7:0];
    end

    assign bus.mem_rdata = rdata_q;
    assign bus.mem_fault = fault_q;
    assign led_out       = led_q;
    assign tx_valid      = !fifo_empty;
    assign tx_data       = fifo_empty ? 8'h00 : fifo_mem[rptr_q];

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: expected bus responses and TX bytes are queued at
// stimulus time and popped by a monitor whenever the DUT presents a response or handshake.
module tb_mem_io_responder;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] led_out;
    logic [9:0] sw_in = '0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;

    mem_io_responder_if bus ();

    mem_io_responder #(.RAM_WORDS(1024), .FIFO_DEPTH(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .led_out  (led_out),
        .sw_in    (sw_in),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [15:0] rdata;
        logic        fault;
    } exp_t;

    exp_t        rsp_q[$];
    logic [7:0]  tx_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] last_rdata = '0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One-cycle strobe; rdata is expected to hold unless this is a pure read.
    task automatic access(string name, bit rd, bit wr, logic [15:0] addr, logic [15:0] wdata,
                          logic [15:0] rexp, bit fexp);
        exp_t e;
        if (rd && !wr) last_rdata = rexp;
        e.name  = name;
        e.rdata = last_rdata;
        e.fault = fexp;
        rsp_q.push_back(e);
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_read  = rd;
        bus.mem_write = wr;
        @(posedge clock);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic wr(string name, logic [15:0] addr, logic [15:0] data, bit fexp);
        access(name, 1'b0, 1'b1, addr, data, 16'h0000, fexp);
    endtask

    task automatic rd(string name, logic [15:0] addr, logic [15:0] rexp, bit fexp);
        access(name, 1'b1, 1'b0, addr, 16'h0000, rexp, fexp);
    endtask

    task automatic drain_tx(string name);
        for (int i = 0; i < 20 && tx_valid; i++) idle(1);
        check({name, " tx_valid low"}, 32'(tx_valid), 32'd0);
        check({name, " tx bytes all seen"}, 32'(tx_q.size()), 32'd0);
    endtask

    initial begin : monitor
        bit   pend;
        exp_t e;
        forever begin
            @(posedge clock);
            pend = reset && (bus.mem_read || bus.mem_write);
            @(negedge clock);
            if (pend) begin
                vectors++;
                if (rsp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected response: rdata 0x%04h fault %0b, none queued",
                             bus.mem_rdata, bus.mem_fault);
                end else begin
                    e = rsp_q.pop_front();
                    if (bus.mem_rdata !== e.rdata || bus.mem_fault !== e.fault) begin
                        miscompares++;
                        $display("FAIL %s: got rdata 0x%04h fault %0b, want rdata 0x%04h fault %0b",
                                 e.name, bus.mem_rdata, bus.mem_fault, e.rdata, e.fault);
                    end
                end
            end
            if (tx_valid && tx_ready) begin
                vectors++;
                if (tx_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected tx byte: got 0x%02h, none queued", tx_data);
                end else if (tx_data !== tx_q[0]) begin
                    miscompares++;
                    $display("FAIL tx byte order: got 0x%02h, want 0x%02h", tx_data, tx_q[0]);
                    void'(tx_q.pop_front());
                end else begin
                    void'(tx_q.pop_front());
                end
            end
        end
    end

    initial begin : stimulus
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;

        idle(2);
        check("reset rdata", 32'(bus.mem_rdata), 32'h0);
        check("reset fault", 32'(bus.mem_fault), 32'h0);
        check("reset led_out", 32'(led_out), 32'h0);
        check("reset tx_valid", 32'(tx_valid), 32'h0);
        check("reset tx_data", 32'(tx_data), 32'h0);
        reset = 1'b1;
        idle(1);

        // RAM round trip, plus the last RAM word and the first address past it
        wr("ram wr a5", 16'h00A5, 16'h1234, 1'b0);
        rd("ram rd a5", 16'h00A5, 16'h1234, 1'b0);
        wr("ram wr top", 16'h03FF, 16'hCAFE, 1'b0);
        rd("ram rd top", 16'h03FF, 16'hCAFE, 1'b0);
        rd("rd past ram", 16'h0400, 16'h0000, 1'b1);

        // LEDs and switches
        wr("led wr", 16'hFF00, 16'hFFFF, 1'b0);
        check("led_out after wr", 32'(led_out), 32'h3FF);
        rd("led rd", 16'hFF00, 16'h03FF, 1'b0);
        sw_in = 10'h155;
        idle(2);
        rd("sw rd", 16'hFF01, 16'h0155, 1'b0);
        wr("sw wr faults", 16'hFF01, 16'h0000, 1'b1);
        rd("led rd after fault", 16'hFF00, 16'h03FF, 1'b0);

        // FIFO fill and overflow with the consumer stalled
        for (int i = 0; i < 8; i++) wr("fifo push", 16'hFF02, 16'(8'h41 + i), 1'b0);
        rd("status full", 16'hFF02, 16'h4008, 1'b0);
        wr("fifo push ovf", 16'hFF02, 16'h0049, 1'b0);
        rd("status ovf", 16'hFF02, 16'hC008, 1'b0);
        rd("status ovf cleared", 16'hFF02, 16'h4008, 1'b0);
        for (int i = 0; i < 8; i++) tx_q.push_back(8'(8'h41 + i));
        tx_ready = 1'b1;
        drain_tx("fill");
        rd("status empty", 16'hFF02, 16'h2000, 1'b0);
        tx_ready = 1'b0;

        // Full FIFO: push and pop in the same cycle keep count at 8 with no overflow
        for (int i = 0; i < 8; i++) wr("fifo refill", 16'hFF02, 16'(8'h50 + i), 1'b0);
        for (int i = 0; i < 8; i++) tx_q.push_back(8'(8'h50 + i));
        tx_q.push_back(8'h5A);
        tx_ready = 1'b1;
        wr("push while popping", 16'hFF02, 16'h005A, 1'b0);
        rd("status full no ovf", 16'hFF02, 16'h4008, 1'b0);
        drain_tx("full push/pop");
        tx_ready = 1'b0;

        // Counter: cleared at the write edge and 0 the cycle after, so a read strobe issued
        // ten cycles after the clear strobe samples 9.
        wr("cnt clear", 16'hFF03, 16'h0000, 1'b0);
        idle(9);
        rd("cnt after 9 idle", 16'hFF03, 16'd9, 1'b0);

        // Shadow: read strobe k cycles after the clear sees counter k-1
        wr("cnt clear 2", 16'hFF03, 16'h1234, 1'b0);
        idle(65534);
        rd("cnt low ffff-1", 16'hFF03, 16'hFFFE, 1'b0);
        rd("shadow before wrap", 16'hFF04, 16'h0000, 1'b0);
        idle(3);
        rd("cnt low 10003", 16'hFF03, 16'h0003, 1'b0);
        rd("shadow after wrap", 16'hFF04, 16'h0001, 1'b0);

        // Faults
        rd("unmapped rd", 16'h8000, 16'h0000, 1'b1);
        rd("fault is one pulse", 16'hFF00, 16'h03FF, 1'b0);
        access("rd+wr same cycle", 1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b1);
        rd("rd+wr write landed", 16'h0010, 16'hBEEF, 1'b0);
        wr("shadow wr faults", 16'hFF04, 16'h0000, 1'b1);
        wr("unmapped wr", 16'h9000, 16'h5555, 1'b1);
        rd("unmapped rd 2", 16'hFF05, 16'h0000, 1'b1);

        // Asynchronous reset with three bytes queued
        for (int i = 0; i < 3; i++) wr("pre-reset push", 16'hFF02, 16'(8'h61 + i), 1'b0);
        idle(1);
        check("pre-reset tx_valid", 32'(tx_valid), 32'h1);
        check("pre-reset tx_data", 32'(tx_data), 32'h61);
        #2;
        reset = 1'b0;
        last_rdata = '0;
        #1;
        check("async reset tx_valid", 32'(tx_valid), 32'h0);
        check("async reset tx_data", 32'(tx_data), 32'h0);
        check("async reset led_out", 32'(led_out), 32'h0);
        check("async reset rdata", 32'(bus.mem_rdata), 32'h0);
        idle(2);
        reset = 1'b1;
        idle(1);
        rd("post-reset status", 16'hFF02, 16'h2000, 1'b0);
        rd("post-reset led", 16'hFF00, 16'h0000, 1'b0);
        rd("ram kept over reset", 16'h00A5, 16'h1234, 1'b0);

        idle(2);
        check("responses all seen", 32'(rsp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
